// File: rtl/menu_navigator.sv
// menu_navigator: parameterised on-screen menu navigation engine.
//
// Takes debounced active-low buttons. Drives the selected item index, one value
// register per item, and one-cycle ACTION / VALUE_CHG strobes.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   EN                   1 = menu active, 0 = events ignored (repeat FSM idled)
//   BTN_DEB_*            debounced button levels, 0 = pressed
//   ITEM_KIND            2 bits per item: 0 action, 1 clamped value,
//                        2 wrapping value, 3 disabled
//   ITEM_MIN/MAX/INIT    VAL_W bits per item, item i at [i*VAL_W +: VAL_W]
//   SEL                  selected item index
//   VALUES               item values, same packing as ITEM_INIT
//   ACTION, ACTION_ID    ENTER on an action item (strobe + index)
//   VALUE_CHG            strobe when a stored value actually changed
//
// Build option: define MENU_NAV_AUTOREPEAT_EN to build the hold-to-repeat FSM
// for UP/DOWN/LEFT/RIGHT. Without it, only press edges generate events.
module menu_navigator #(
  parameter int N_ITEMS       = 4,
  parameter int VAL_W         = 5,
  parameter int SEL_WRAP      = 0,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         BTN_DEB_UP,
  input  logic                         BTN_DEB_DOWN,
  input  logic                         BTN_DEB_LEFT,
  input  logic                         BTN_DEB_RIGHT,
  input  logic                         BTN_DEB_ENTER,
  input  logic [2*N_ITEMS-1:0]         ITEM_KIND,
  input  logic [VAL_W*N_ITEMS-1:0]     ITEM_MIN,
  input  logic [VAL_W*N_ITEMS-1:0]     ITEM_MAX,
  input  logic [VAL_W*N_ITEMS-1:0]     ITEM_INIT,
  output logic [$clog2(N_ITEMS)-1:0]   SEL,
  output logic [VAL_W*N_ITEMS-1:0]     VALUES,
  output logic                         ACTION,
  output logic [$clog2(N_ITEMS)-1:0]   ACTION_ID,
  output logic                         VALUE_CHG
);
  localparam int SEL_W = $clog2(N_ITEMS);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_ITEMS - 1);
  localparam logic [1:0] K_ACT = 2'd0, K_CLAMP = 2'd1, K_WRAP = 2'd2;

  // Button bit order: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ENTER.
  // Both stages reset to "pressed" so a button held through reset must be
  // released and pressed again before it generates an event.
  logic [4:0] btn_q, btn_q2, press;

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_q  <= '0;
      btn_q2 <= '0;
    end else begin
      btn_q  <= {BTN_DEB_ENTER, BTN_DEB_RIGHT, BTN_DEB_LEFT, BTN_DEB_DOWN, BTN_DEB_UP};
      btn_q2 <= btn_q;
    end
  end

  assign press = btn_q2 & ~btn_q;

  logic       ev_vld, ev_enter;
  logic [1:0] ev_dir;

`ifdef MENU_NAV_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_t;

  rpt_state_t       state_q, state_d;
  logic [1:0]       key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held, rpt_fire, new_key;

  assign held     = ~btn_q[key_q];
  // A winning direction press (ENTER outranks directions and never latches).
  assign new_key  = EN && !press[4] && (|press[3:0]);
  assign rpt_fire = held &&
                    ((state_q == S_DELAY  && cnt_q == CNT_W'(REPEAT_DELAY - 1)) ||
                     (state_q == S_REPEAT && cnt_q == CNT_W'(REPEAT_PERIOD - 1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q + 1'b1;
    if (!EN) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (new_key) begin
      state_d = S_DELAY;
      key_d   = ev_dir;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (!held) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            state_d = S_REPEAT;
            cnt_d   = '0;
          end
        end
        S_REPEAT: begin
          if (!held) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            cnt_d = '0;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end
`endif

  // One event per cycle. Dropped lower-priority presses are not queued.
  always_comb begin
    ev_vld   = 1'b0;
    ev_enter = 1'b0;
    ev_dir   = 2'd0;
    if (EN) begin
      if (press[4]) begin
        ev_vld   = 1'b1;
        ev_enter = 1'b1;
      end else if (|press[3:0]) begin
        ev_vld = 1'b1;
        ev_dir = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
      end
`ifdef MENU_NAV_AUTOREPEAT_EN
      else if (rpt_fire) begin
        ev_vld = 1'b1;
        ev_dir = key_q;
      end
`endif
    end
  end

  // Value datapath for the selected item.
  logic [N_ITEMS-1:0][VAL_W-1:0] vals_q;
  logic [SEL_W-1:0]              sel_q, sel_d, aid_q;
  logic                          act_q, act_d, chg_q, chg_d, wr;
  logic [1:0]                    kind;
  logic [VAL_W-1:0]              cur_v, mn, mx, inc_v, dec_v, new_v;
  logic                          is_val, inc_wrap;

  assign kind   = ITEM_KIND[{sel_q, 1'b0} +: 2];
  assign cur_v  = vals_q[sel_q];
  assign mn     = ITEM_MIN[int'(sel_q) * VAL_W +: VAL_W];
  assign mx     = ITEM_MAX[int'(sel_q) * VAL_W +: VAL_W];
  assign is_val = (kind == K_CLAMP) || (kind == K_WRAP);
  // ENTER always increments with wrap, whatever the item kind.
  assign inc_wrap = ev_enter || (kind == K_WRAP);
  // >= / <= compares pull an out-of-range value back into range.
  assign inc_v  = (cur_v >= mx) ? (inc_wrap ? mn : mx) : cur_v + 1'b1;
  assign dec_v  = (cur_v <= mn) ? ((kind == K_WRAP) ? mx : mn) : cur_v - 1'b1;

  always_comb begin
    sel_d = sel_q;
    new_v = cur_v;
    wr    = 1'b0;
    act_d = 1'b0;
    if (ev_vld) begin
      if (ev_enter) begin
        if (kind == K_ACT) act_d = 1'b1;
        else if (is_val) begin
          new_v = inc_v;
          wr    = 1'b1;
        end
      end else begin
        case (ev_dir)
          2'd0: sel_d = (sel_q == '0) ? ((SEL_WRAP != 0) ? SEL_MAX : '0) : sel_q - 1'b1;
          2'd1: sel_d = (sel_q == SEL_MAX) ? ((SEL_WRAP != 0) ? '0 : SEL_MAX) : sel_q + 1'b1;
          2'd2: if (is_val) begin new_v = dec_v; wr = 1'b1; end
          default: if (is_val) begin new_v = inc_v; wr = 1'b1; end
        endcase
      end
    end
    chg_d = wr && (new_v != cur_v);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q  <= '0;
      vals_q <= ITEM_INIT;
      act_q  <= 1'b0;
      aid_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      if (wr) vals_q[sel_q] <= new_v;
      act_q <= act_d;
      if (act_d) aid_q <= sel_q;
      chg_q <= chg_d;
    end
  end

  assign SEL       = sel_q;
  assign VALUES    = vals_q;
  assign ACTION    = act_q;
  assign ACTION_ID = aid_q;
  assign VALUE_CHG = chg_q;
endmodule

// File: tb/tb_menu_navigator.sv
// Testbench for menu_navigator. Two instances share the inputs: one with a
// clamping cursor and one with a wrapping cursor. A behavioural model (press
// detection, run-length repeat timing, value arithmetic) predicts every
// output each cycle. Directed test-plan scenarios are followed by randomised
// button activity. Autorepeat expectations follow MENU_NAV_AUTOREPEAT_EN.
module tb_menu_navigator;
  localparam int N = 4, W = 5, D = 8, P = 4;
  localparam logic [4:0] M_UP = 5'd1, M_DN = 5'd2, M_LT = 5'd4, M_RT = 5'd8, M_EN = 5'd16;
  localparam logic [19:0] MINV  = {5'd0, 5'd1,  5'd1,  5'd0};
  localparam logic [19:0] MAXV  = {5'd2, 5'd20, 5'd20, 5'd0};
  localparam logic [19:0] INITV = {5'd0, 5'd3,  5'd3,  5'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b1;
  logic [4:0] b = '1;               // levels, 1 = released; bit0 UP .. bit4 ENTER
  logic [7:0] kind = 8'h94;         // {wrap, clamp, clamp, action}

  logic [1:0]  sel_o [2];
  logic [19:0] val_o [2];
  logic        act_o [2];
  logic [1:0]  aid_o [2];
  logic        chg_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    menu_navigator #(.N_ITEMS(N), .VAL_W(W), .SEL_WRAP(g),
                     .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) u_dut (
      .CLK(clk), .RST(rst), .EN(en),
      .BTN_DEB_UP(b[0]), .BTN_DEB_DOWN(b[1]), .BTN_DEB_LEFT(b[2]),
      .BTN_DEB_RIGHT(b[3]), .BTN_DEB_ENTER(b[4]),
      .ITEM_KIND(kind), .ITEM_MIN(MINV), .ITEM_MAX(MAXV), .ITEM_INIT(INITV),
      .SEL(sel_o[g]), .VALUES(val_o[g]), .ACTION(act_o[g]),
      .ACTION_ID(aid_o[g]), .VALUE_CHG(chg_o[g]));
  end

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_sel [2];
  int         m_val [2][4];
  bit         m_act [2];
  int         m_aid [2];
  bit         m_chg [2];
  logic [4:0] m_s1, m_s2;           // last and previous sampled levels
  int         m_L = -1, m_t = 0;    // latched key and edges since its event

  function automatic int incf(int v, int mn, int mx, bit w);
    return (v >= mx) ? (w ? mn : mx) : v + 1;
  endfunction
  function automatic int decf(int v, int mn, int mx, bit w);
    return (v <= mn) ? (w ? mx : mn) : v - 1;
  endfunction

  task automatic apply(input int d, input int ev);
    int s, k, v, mn, mx, nv;
    s  = m_sel[d];
    k  = int'((kind >> (2 * s)) & 8'd3);
    v  = m_val[d][s];
    mn = int'(MINV[s*W +: W]);
    mx = int'(MAXV[s*W +: W]);
    nv = v;
    m_act[d] = 1'b0;
    case (ev)
      4: if (k == 0) begin m_act[d] = 1'b1; m_aid[d] = s; end
         else if (k != 3) nv = incf(v, mn, mx, 1'b1);
      0: m_sel[d] = (s == 0) ? (d == 1 ? 3 : 0) : s - 1;
      1: m_sel[d] = (s == 3) ? (d == 1 ? 0 : 3) : s + 1;
      2: if (k == 1 || k == 2) nv = decf(v, mn, mx, k == 2);
      3: if (k == 1 || k == 2) nv = incf(v, mn, mx, k == 2);
      default: ;
    endcase
    m_chg[d] = (nv != v);
    m_val[d][s] = nv;
  endtask

  task automatic model_step();
    logic [4:0] pr;
    int ev;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_sel[d] = 0; m_act[d] = 0; m_aid[d] = 0; m_chg[d] = 0;
        for (int i = 0; i < 4; i++) m_val[d][i] = int'(INITV[i*W +: W]);
      end
      m_s1 = '0; m_s2 = '0; m_L = -1; m_t = 0;
      return;
    end
    pr = m_s2 & ~m_s1;
    ev = -1;
    if (en) begin
`ifdef MENU_NAV_AUTOREPEAT_EN
      if (m_L >= 0 && m_s1[m_L]) m_L = -1;
`endif
      if (pr[4]) ev = 4;
      else for (int k = 0; k < 4; k++) if (ev < 0 && pr[k]) ev = k;
`ifdef MENU_NAV_AUTOREPEAT_EN
      if (ev >= 0 && ev < 4) begin
        m_L = ev; m_t = 0;
      end else if (m_L >= 0) begin
        m_t++;
        if (ev < 0 && (m_t == D || (m_t > D && (m_t - D) % P == 0))) ev = m_L;
      end
`endif
    end else m_L = -1;
    for (int d = 0; d < 2; d++) apply(d, ev);
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  // ---------------- stimulus helpers ----------------
  int         n_chg = 0, n_act = 0;
  logic [1:0] last_aid = '0;

  task automatic tick();
    logic [19:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = '0;
      for (int i = 0; i < 4; i++) e[i*W +: W] = 5'(m_val[d][i]);
      chk($sformatf("sel%0d", d), 32'(sel_o[d]), m_sel[d]);
      chk($sformatf("vals%0d", d), 32'(val_o[d]), 32'(e));
      chk($sformatf("act%0d", d), 32'(act_o[d]), 32'(m_act[d]));
      chk($sformatf("chg%0d", d), 32'(chg_o[d]), 32'(m_chg[d]));
      if (m_act[d]) chk($sformatf("aid%0d", d), 32'(aid_o[d]), m_aid[d]);
    end
    if (chg_o[0] === 1'b1) n_chg++;
    if (act_o[0] === 1'b1) begin n_act++; last_aid = aid_o[0]; end
  endtask

  task automatic hold(input logic [4:0] m, input int n);
    b = ~m;
    repeat (n) tick();
  endtask

  task automatic tap(input logic [4:0] m);
    hold(m, 2);
    hold(5'd0, 2);
  endtask

  initial begin
    int r;
    logic [4:0] m;
    tick(); tick();
    rst = 1'b0;
    hold(5'd0, 2);
    chk("rst_sel", 32'(sel_o[0]), 0);
    chk("rst_vals", 32'(val_o[0]), 32'(INITV));

    tap(M_UP);
    chk("up_clamp", 32'(sel_o[0]), 0);
    chk("up_wrap", 32'(sel_o[1]), 3);

    rst = 1'b1; tick(); rst = 1'b0; hold(5'd0, 2);
    tap(M_DN);
    n_chg = 0;
    repeat (18) tap(M_RT);
    chk("rt_pulses", n_chg, 17);
    chk("rt_max", 32'(val_o[0][9:5]), 20);
    n_chg = 0;
    tap(M_EN);
    chk("ent_wrap", 32'(val_o[0][9:5]), 1);
    chk("ent_chg", n_chg, 1);

    tap(M_DN); tap(M_DN);
    repeat (3) tap(M_EN);
    chk("it3_wrap", 32'(val_o[0][19:15]), 0);
    repeat (3) tap(M_UP);
    n_act = 0;
    tap(M_EN);
    chk("act_cnt", n_act, 1);
    chk("act_id", 32'(last_aid), 0);

    tap(M_DN);
    n_chg = 0;
    hold(M_RT, 20);
    hold(5'd0, 10);
`ifdef MENU_NAV_AUTOREPEAT_EN
    chk("rpt_incs", n_chg, 4);
`else
    chk("rpt_incs", n_chg, 1);
`endif

    tap(M_UP);
    n_act = 0;
    tap(M_EN | M_DN);
    chk("sim_act", n_act, 1);
    chk("sim_sel", 32'(sel_o[0]), 0);
    en = 1'b0; n_act = 0;
    tap(M_EN | M_DN);
    chk("en0_act", n_act, 0);
    chk("en0_sel", 32'(sel_o[0]), 0);
    en = 1'b1;

    hold(M_DN, 12);
    rst = 1'b1; tick(); rst = 1'b0;
    n_chg = 0;
    hold(M_DN, 12);
    chk("rsthold_sel", 32'(sel_o[0]), 0);
    chk("rsthold_vals", 32'(val_o[0]), 32'(INITV));
    hold(5'd0, 2);
    tap(M_DN);
    chk("repress_sel", 32'(sel_o[0]), 1);

    // Randomised activity; item 2 toggles between clamped and disabled.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (it % 100 == 50) kind[5:4] = (kind[5:4] == 2'd1) ? 2'd3 : 2'd1;
      if (r < 3) begin rst = 1'b1; tick(); rst = 1'b0; end
      else if (r < 10) en = ~en;
      m = 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) m = m | 5'(1 << $urandom_range(0, 4));
      hold(m, $urandom_range(1, 22));
      hold(5'd0, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/menu_navigator.md
# menu_navigator

Generic, parametrised menu navigation engine for the on-screen menus: debounced active-low buttons in; selected item index, per-item value registers and action strobes out. It replaces hand-written per-screen navigation logic in the game top level. It adds item kinds with per-item min/max, optional wrap of the selection cursor, LEFT/RIGHT value adjustment and hold-to-repeat. It sits between the DEBOUNCE instances and the game-state register feeding the VGA renderer.

## Interface
- N_ITEMS, 4: number of menu entries (2..16).
- VAL_W, 5: width of each item value.
- SEL_WRAP, 0: 0 = cursor clamps at 0 / N_ITEMS-1; 1 = cursor wraps.
- REPEAT_DELAY, 12500000: hold cycles after the first event before auto-repeat starts (≥2).
- REPEAT_PERIOD, 2500000: cycles between repeated events (≥1).
- CLK  in  1  system clock (CLK_PLL domain).
- RST  in  1  synchronous, active-high reset.
- EN  in  1  1 = menu active; 0 = events ignored.
- BTN_DEB_UP, BTN_DEB_DOWN, BTN_DEB_LEFT, BTN_DEB_RIGHT, BTN_DEB_ENTER  in  1 each  debounced levels, 0 = pressed.
- ITEM_KIND  in  2*N_ITEMS  per item: 0 = action, 1 = value clamped, 2 = value wrapping, 3 = disabled (cursor skips nothing; events ignored).
- ITEM_MIN, ITEM_MAX, ITEM_INIT  in  VAL_W*N_ITEMS each  per-item bounds and reset value; item i occupies bits [i*VAL_W +: VAL_W].
- SEL  out  $clog2(N_ITEMS)  selected item index.
- VALUES  out  VAL_W*N_ITEMS  current item values, same packing.
- ACTION  out  1  one-cycle strobe: ENTER on an action item.
- ACTION_ID  out  $clog2(N_ITEMS)  item index, valid when ACTION=1.
- VALUE_CHG  out  1  one-cycle strobe: a value register changed (renderer must recompute layout).

## Operation
- Input stage: each button registered into btn_q; press = btn_q 1→0 on consecutive samples.
- One event per cycle; priority ENTER > UP > DOWN > LEFT > RIGHT; lower-priority simultaneous presses are dropped, not queued.
- UP: SEL-1; DOWN: SEL+1. At the bounds: hold (SEL_WRAP=0) or wrap to N_ITEMS-1 / 0 (SEL_WRAP=1).
- RIGHT/LEFT on a value item: inc/dec. On action or disabled items: no effect.
- inc: v ≥ max → (wrapping ? min : max), else v+1. dec: v ≤ min → (wrapping ? max : min), else v-1. An out-of-range value is thus pulled back into range by one adjust.
- ENTER on a value item: inc with wrap semantics regardless of kind. ENTER on an action item: ACTION=1, ACTION_ID=SEL. ENTER on a disabled item: ignored.
- VALUE_CHG pulses only when the stored value actually differs (saturated inc at max gives no pulse).
- Repeat FSM: IDLE → DELAY on a press event of UP/DOWN/LEFT/RIGHT; the key is latched. DELAY → REPEAT after REPEAT_DELAY cycles held. REPEAT issues an event every REPEAT_PERIOD cycles. Release of the latched key → IDLE. ENTER never repeats. A new press of a different key re-latches and restarts DELAY.
- EN=0: no events, FSM forced to IDLE, btn_q still sampled; SEL/VALUES hold.

## Timing
- Reset: SEL=0, VALUES=ITEM_INIT, ACTION=0, ACTION_ID=0, VALUE_CHG=0, FSM=IDLE. btn_q is reset to 0 (pressed), so a button held through reset fires only after release and re-press.
- Latency: first rising edge sampling a button low = edge n; SEL/VALUES/strobes update at edge n+1.
- Repeat: first repeated event is applied REPEAT_DELAY cycles after the initial event; subsequent events every REPEAT_PERIOD cycles.
- All outputs registered; strobes are high exactly one cycle.
- RST mid-hold or mid-repeat: the state above applies at the next edge and no further events occur until release.

## Configuration
- MENU_NAV_AUTOREPEAT_EN defined: repeat FSM and its counter are built as described.
- Not defined: FSM and counter are omitted; only press edges generate events, and REPEAT_DELAY/REPEAT_PERIOD are ignored.

## Test plan
All scenarios use N_ITEMS=4, VAL_W=5, REPEAT_DELAY=8, REPEAT_PERIOD=4, kinds {action, clamp, clamp, wrap}, MIN {0,1,1,0}, MAX {0,20,20,2}, INIT {0,3,3,0}.
- Reset, then press UP 1× at SEL=0 with SEL_WRAP=0 → SEL stays 0; with SEL_WRAP=1 → SEL=3.
- DOWN 1×, RIGHT 18× → item1 reaches 20 with 17 VALUE_CHG pulses; 18th press gives no pulse. ENTER → item1=1, VALUE_CHG=1.
- SEL=3, ENTER 3× → item3 goes 1, 2, 0; SEL=0, ENTER → ACTION=1 for one cycle, ACTION_ID=0.
- SEL=1, hold RIGHT 20 cycles (autorepeat built) → events at hold cycles 1, 9, 13, 17 (4 increments); release → no more events. Without the macro → 1 increment.
- ENTER and DOWN pressed in the same cycle at SEL=0 → ACTION only, SEL unchanged. Same with EN=0 → nothing.
- Hold DOWN, assert RST for 1 cycle mid-repeat → SEL=0, VALUES=INIT, no events until DOWN is released and pressed again.
